// File: rtl/byte_packer_pkg.sv
// Shared definitions for the byte/word lane family (swapper, packer, unpacker).
// Contents:
//   WORD_W, BYTE_W, LANES - word geometry
//   lane_index(i, big_endian) - byte lane that holds the i-th byte of a word
package byte_packer_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANES  = WORD_W / BYTE_W;

  // Big-endian order puts the first byte in the most significant lane.
  function automatic logic [1:0] lane_index(input logic [1:0] i, input bit big_endian);
    return big_endian ? 2'(2'd3 - i) : i;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a valid/ready byte stream into 32-bit words in a selectable byte
// order. A packet ending mid-word is flushed with a partial keep mask.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_byte, in_valid, in_last    byte stream input (in_last qualified by in_valid)
//   in_ready                      byte accepted when in_valid && in_ready
//   out_word, out_keep, out_valid packed word, lane-valid mask, word valid
//   out_ready                     downstream consumes the word
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [LANES-1:0]  out_keep,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [WORD_W-1:0] acc;
  logic [1:0]        count;
  logic              accept;
  logic              complete;
  logic [1:0]        lane;
  logic [WORD_W-1:0] merged;
  logic [LANES-1:0]  keep_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign complete = (count == 2'd3) || in_last;
  assign lane     = lane_index(count, BIG_ENDIAN);

  // The keep mask is derived from count rather than stored: lanes 0..count
  // (in byte order) are the ones filled once the current byte is merged.
  always_comb begin
    merged = acc;
    merged[int'(lane) * BYTE_W +: BYTE_W] = in_byte;
    keep_next = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      if (j <= 32'(count)) begin
        keep_next[lane_index(2'(j), BIG_ENDIAN)] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      out_word  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A word loaded here overrides the consume above, so a simultaneous
      // consume-and-complete keeps out_valid high with the new word.
      if (accept) begin
        if (complete) begin
          out_word  <= merged;
          out_keep  <= keep_next;
          out_valid <= 1'b1;
          acc       <= '0;
          count     <= '0;
        end else begin
          acc   <= merged;
          count <= count + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_packer.sv
module tb_byte_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic        be_rdy, le_rdy;
  logic [31:0] be_word, le_word;
  logic [3:0]  be_keep, le_keep;
  logic        be_ov, le_ov;

  always #5 clk = ~clk;

  byte_packer #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(be_rdy), .out_word(be_word), .out_keep(be_keep), .out_valid(be_ov),
    .out_ready(out_ready)
  );

  byte_packer #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(le_rdy), .out_word(le_word), .out_keep(le_keep), .out_valid(le_ov),
    .out_ready(out_ready)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: bytes of the word being built, and the words expected
  // to appear at the output (the output register holds at most one).
  logic [7:0]  cur[$];
  logic [31:0] q_be[$], q_le[$];
  logic [3:0]  q_kbe[$], q_kle[$];

  typedef struct {
    logic [7:0]  b;
    logic        v, l, r;
    logic        exp_ov;
    logic [31:0] exp_be;
    logic [3:0]  exp_kbe;
    logic [31:0] exp_le;
    logic [3:0]  exp_kle;
  } vec_t;

  logic tab_active = 1'b0;
  vec_t tab_cur;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic emit();
    logic [31:0] wbe, wle;
    logic [3:0]  kbe, kle;
    wbe = '0; wle = '0; kbe = '0; kle = '0;
    for (int k = 0; k < cur.size(); k++) begin
      wbe = wbe | (32'(cur[k]) << (24 - 8 * k));
      wle = wle | (32'(cur[k]) << (8 * k));
      kbe[3 - k] = 1'b1;
      kle[k]     = 1'b1;
    end
    q_be.push_back(wbe); q_kbe.push_back(kbe);
    q_le.push_back(wle); q_kle.push_back(kle);
    cur.delete();
  endtask

  task automatic model_reset();
    cur.delete();
    q_be.delete(); q_kbe.delete(); q_le.delete(); q_kle.delete();
  endtask

  task automatic step(input logic [7:0] b, input logic v, input logic l, input logic r);
    logic exp_ov, exp_rdy;
    @(negedge clk);
    in_byte = b; in_valid = v; in_last = l; out_ready = r;
    #1;
    exp_ov  = (q_be.size() != 0);
    exp_rdy = !exp_ov || r;
    chk("out_valid_be", 32'(be_ov), 32'(exp_ov));
    chk("out_valid_le", 32'(le_ov), 32'(exp_ov));
    chk("in_ready_be", 32'(be_rdy), 32'(exp_rdy));
    chk("in_ready_le", 32'(le_rdy), 32'(exp_rdy));
    if (exp_ov) begin
      chk("out_word_be", be_word, q_be[0]);
      chk("out_keep_be", 32'(be_keep), 32'(q_kbe[0]));
      chk("out_word_le", le_word, q_le[0]);
      chk("out_keep_le", 32'(le_keep), 32'(q_kle[0]));
    end
    if (tab_active) begin
      chk("tab_valid", 32'(be_ov), 32'(tab_cur.exp_ov));
      if (tab_cur.exp_ov) begin
        chk("tab_word_be", be_word, tab_cur.exp_be);
        chk("tab_keep_be", 32'(be_keep), 32'(tab_cur.exp_kbe));
        chk("tab_word_le", le_word, tab_cur.exp_le);
        chk("tab_keep_le", 32'(le_keep), 32'(tab_cur.exp_kle));
      end
    end
    @(posedge clk);
    if (exp_ov && r) begin
      void'(q_be.pop_front()); void'(q_kbe.pop_front());
      void'(q_le.pop_front()); void'(q_kle.pop_front());
    end
    if (v && exp_rdy) begin
      cur.push_back(b);
      if (cur.size() == 4 || l) emit();
    end
  endtask

  // Assert reset between clock edges and check it takes effect at once.
  task automatic async_reset();
    #2;
    in_valid = 1'b0; in_last = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_out_valid_be", 32'(be_ov), 32'd0);
    chk("rst_out_valid_le", 32'(le_ov), 32'd0);
    chk("rst_out_word_be", be_word, 32'd0);
    chk("rst_out_keep_be", 32'(be_keep), 32'd0);
    chk("rst_in_ready", 32'(be_rdy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tab[$];

  initial begin
    rst = 1'b1; in_byte = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;

    // b, v, l, r, exp_ov, exp_be, exp_kbe, exp_le, exp_kle (outputs before the edge)
    tab.push_back('{8'h11, 1, 0, 1, 0, 32'h0,        4'h0, 32'h0,        4'h0});
    tab.push_back('{8'h22, 1, 0, 1, 0, 32'h0,        4'h0, 32'h0,        4'h0});
    tab.push_back('{8'h33, 1, 0, 1, 0, 32'h0,        4'h0, 32'h0,        4'h0});
    tab.push_back('{8'h44, 1, 0, 1, 0, 32'h0,        4'h0, 32'h0,        4'h0});
    tab.push_back('{8'hAA, 1, 0, 1, 1, 32'h11223344, 4'hF, 32'h44332211, 4'hF});
    tab.push_back('{8'hBB, 1, 1, 1, 0, 32'h0,        4'h0, 32'h0,        4'h0});
    tab.push_back('{8'hCC, 1, 0, 1, 1, 32'hAABB0000, 4'hC, 32'h0000BBAA, 4'h3});
    tab.push_back('{8'hDD, 1, 0, 1, 0, 32'h0,        4'h0, 32'h0,        4'h0});
    tab.push_back('{8'hEE, 1, 1, 1, 0, 32'h0,        4'h0, 32'h0,        4'h0});
    tab.push_back('{8'h00, 0, 0, 1, 1, 32'hCCDDEE00, 4'hE, 32'h00EEDDCC, 4'h7});
    tab.push_back('{8'h77, 1, 1, 1, 0, 32'h0,        4'h0, 32'h0,        4'h0});
    tab.push_back('{8'h00, 0, 0, 1, 1, 32'h77000000, 4'h8, 32'h00000077, 4'h1});
    tab.push_back('{8'h99, 0, 1, 1, 0, 32'h0,        4'h0, 32'h0,        4'h0});
    tab.push_back('{8'h00, 0, 0, 1, 0, 32'h0,        4'h0, 32'h0,        4'h0});

    #3;
    chk("reset_out_valid", 32'(be_ov), 32'd0);
    chk("reset_out_word", be_word, 32'd0);
    chk("reset_out_keep", 32'(be_keep), 32'd0);
    chk("reset_in_ready", 32'(be_rdy), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    tab_active = 1'b1;
    for (int i = 0; i < tab.size(); i++) begin
      tab_cur = tab[i];
      step(tab[i].b, tab[i].v, tab[i].l, tab[i].r);
    end
    tab_active = 1'b0;

    // Backpressure: stall with a word pending while a byte waits.
    step(8'h11, 1, 0, 1); step(8'h22, 1, 0, 1); step(8'h33, 1, 0, 1); step(8'h44, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(8'h55, 1, 0, 0);
    step(8'h55, 1, 0, 1); step(8'h66, 1, 0, 1); step(8'h77, 1, 0, 1); step(8'h88, 1, 0, 1);
    step(8'h00, 0, 0, 1);

    // Streaming: consume and complete in the same cycle.
    for (int i = 1; i <= 8; i++) step(8'(i), 1, 0, 1);
    step(8'h00, 0, 0, 1); step(8'h00, 0, 0, 1);

    // Reset with a pending word held by backpressure.
    step(8'hE1, 1, 1, 1);
    step(8'h00, 0, 0, 0);
    async_reset();
    step(8'h00, 0, 0, 1);

    // Reset with two bytes accumulated; they must never appear.
    step(8'hA1, 1, 0, 1); step(8'hA2, 1, 0, 1);
    async_reset();
    step(8'h55, 1, 0, 1); step(8'h66, 1, 0, 1); step(8'h77, 1, 0, 1); step(8'h88, 1, 0, 1);
    tab_active = 1'b1;
    tab_cur = '{8'h00, 0, 0, 1, 1, 32'h55667788, 4'hF, 32'h88776655, 4'hF};
    step(8'h00, 0, 0, 1);
    tab_active = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(8'($urandom), $urandom_range(9, 0) < 7, $urandom_range(4, 0) == 0,
           $urandom_range(9, 0) < 7);
    end
    for (int i = 0; i < 4; i++) step(8'h00, 0, 0, 1);
    chk("drained", 32'(q_be.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
